// File: rtl/cmp_search.sv
// cmp_search: recovers a hidden W-bit target by MSB-first successive approximation,
// using an external combinational comparator (guess drives "a", target drives "b").
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous active-high reset
//   start  - request a new search (sampled only while idle)
//   guess  - trial value presented to the comparator
//   g/e/l  - comparator response: guess >, ==, < target (exactly one expected)
//   busy   - high while searching
//   done   - one-cycle pulse when result is valid
//   result - recovered target, held until the next search terminates
//   err    - response-protocol violation seen in the last search
//   steps  - comparisons consumed by the last search
module cmp_search #(
  parameter int unsigned W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [W-1:0]               guess,
  input  logic                       g,
  input  logic                       e,
  input  logic                       l,
  output logic                       busy,
  output logic                       done,
  output logic [W-1:0]               result,
  output logic                       err,
  output logic [$clog2(W+1)-1:0]     steps
);

  localparam int unsigned IW = $clog2(W);
  localparam int unsigned SW = $clog2(W + 1);

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StDone
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] steps_q, steps_d;
  logic          err_q, err_d;

  logic [W-1:0]  bit_mask;
  logic [W-1:0]  probe;
  logic          one_hot;
  logic          last_bit;

  assign bit_mask = {{(W-1){1'b0}}, 1'b1} << idx_q;
  assign probe    = acc_q | bit_mask;
  assign one_hot  = (g & ~e & ~l) | (~g & e & ~l) | (~g & ~e & l);
  assign last_bit = (idx_q == '0);

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    result_d = result_q;
    idx_d    = idx_q;
    steps_d  = steps_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSearch;
          acc_d   = '0;
          err_d   = 1'b0;
          steps_d = '0;
          idx_d   = IW'(W - 1);
        end
      end
      StSearch: begin
        steps_d = steps_q + 1'b1;
        if (!one_hot) begin
          // Malformed response: stop with whatever has been resolved so far.
          err_d    = 1'b1;
          result_d = acc_q;
          state_d  = StDone;
        end else if (e) begin
          // Exact hit: no need to resolve the remaining lower bits.
          acc_d    = probe;
          result_d = probe;
          state_d  = StDone;
        end else begin
          if (l) begin
            acc_d = probe;
          end
          if (last_bit) begin
            result_d = acc_d;
            state_d  = StDone;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      steps_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      steps_q  <= steps_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == StSearch);
  assign done   = (state_q == StDone);
  assign guess  = busy ? probe : result_q;
  assign result = result_q;
  assign err    = err_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_cmp_search.sv
// tb_cmp_search: directed bench for cmp_search (W=4). A comparator model answers the
// DUT's guesses for a target popped at each accepted start; an integer-level model
// predicts every cycle's outputs, and literal expectations pin the scenarios.
module tb_cmp_search;

  localparam int unsigned W  = 4;
  localparam int unsigned SW = $clog2(W + 1);

  logic          clk;
  logic          rst;
  logic          start;
  logic [W-1:0]  guess;
  logic          g;
  logic          e;
  logic          l;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          err;
  logic [SW-1:0] steps;

  cmp_search #(.W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .guess  (guess),
    .g      (g),
    .e      (e),
    .l      (l),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err),
    .steps  (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [W-1:0]  guess;
    logic [W-1:0]  result;
    logic          err;
    logic [SW-1:0] steps;
  } rec_t;

  rec_t         exp_q[$];
  rec_t         cur = '0;
  int           tgt_q[$];
  int           fault_q[$];
  int           obs_q[$];
  logic [W-1:0] tgt = '0;
  int           fstep = 0;
  int           vectors = 0;
  int           errors = 0;
  int           cyc;

  // Comparator; a planted fault forces g=e=1 on the chosen comparison number.
  logic fault_now;
  assign fault_now = cur.busy && ((int'(cur.steps) + 1) == fstep);
  assign g = fault_now | (guess > tgt);
  assign e = fault_now | (guess == tgt);
  assign l = ~fault_now & (guess < tgt);

  // Expected per-cycle trace of one search: each comparison cycle, then the done cycle.
  function automatic void build(input int t, input int f, input logic [W-1:0] prev);
    rec_t         r;
    logic [W-1:0] acc;
    logic [W-1:0] gs;
    int           n;
    logic         bad;
    acc = '0;
    n   = 0;
    bad = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      gs = acc | (W'(1) << i);
      n++;
      r = '{busy: 1'b1, done: 1'b0, guess: gs, result: prev, err: 1'b0, steps: SW'(n - 1)};
      exp_q.push_back(r);
      if (n == f) begin
        bad = 1'b1;
        break;
      end
      if (int'(gs) == t) begin
        acc = gs;
        break;
      end
      if (int'(gs) < t) acc = gs;
    end
    r = '{busy: 1'b0, done: 1'b1, guess: acc, result: acc, err: bad, steps: SW'(n)};
    exp_q.push_back(r);
  endfunction

  // Model: accept start only when the previous expected cycle was idle.
  always @(posedge clk or posedge rst) begin
    rec_t nxt;
    int   t;
    int   f;
    if (rst) begin
      exp_q.delete();
      cur   <= '0;
      tgt   <= '0;
      fstep <= 0;
    end else begin
      if (!cur.busy && !cur.done && start) begin
        t = (tgt_q.size() > 0) ? tgt_q.pop_front() : 0;
        f = (fault_q.size() > 0) ? fault_q.pop_front() : 0;
        build(t, f, cur.result);
        tgt   <= W'(t);
        fstep <= f;
      end
      if (exp_q.size() > 0) begin
        nxt = exp_q.pop_front();
      end else begin
        nxt       = cur;
        nxt.busy  = 1'b0;
        nxt.done  = 1'b0;
        nxt.guess = cur.result;
      end
      cur <= nxt;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    rec_t want;
    rec_t got;
    want = rst ? '0 : cur;
    got  = '{busy: busy, done: done, guess: guess, result: result, err: err, steps: steps};
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL cycle@%0t: got busy=%b done=%b guess=%0d result=%0d err=%b steps=%0d ; required busy=%b done=%b guess=%0d result=%0d err=%b steps=%0d",
               $time, got.busy, got.done, got.guess, got.result, got.err, got.steps,
               want.busy, want.done, want.guess, want.result, want.err, want.steps);
    end
    if (!rst && busy) obs_q.push_back(int'(guess));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input int act, input int req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic check_seq(input string nm, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    check({nm, "_len"}, obs_q.size(), n);
    for (int k = 0; k < n && k < obs_q.size(); k++) begin
      check($sformatf("%s_guess%0d", nm, k), obs_q[k], ex[k]);
    end
  endtask

  // Wait (bounded) for the DUT done pulse; cyc counts cycles since the start edge.
  task automatic wait_done();
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic run(input int t, input int f, input bit poke);
    obs_q.delete();
    tgt_q.push_back(t);
    fault_q.push_back(f);
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    if (poke) begin
      // start while busy must be ignored
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      cyc += 2;
    end
    wait_done();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_guess", int'(guess), 0);
    check("rst_steps", int'(steps), 0);
    rst = 1'b0;

    // Target 11, start on the first edge after reset release, extra start mid-search.
    run(11, 0, 1'b1);
    check_seq("t11", 4, 8, 12, 10, 11);
    check("t11_result", int'(result), 11);
    check("t11_steps", int'(steps), 4);
    check("t11_err", int'(err), 0);
    check("t11_latency", cyc, 5);
    start = 1'b1;  // start during done must be ignored
    tick();
    start = 1'b0;
    tick();

    run(8, 0, 1'b0);
    check_seq("t8", 1, 8, 0, 0, 0);
    check("t8_result", int'(result), 8);
    check("t8_steps", int'(steps), 1);
    check("t8_latency", cyc, 2);
    tick();

    run(0, 0, 1'b0);
    check_seq("t0", 4, 8, 4, 2, 1);
    check("t0_result", int'(result), 0);
    check("t0_steps", int'(steps), 4);
    check("t0_err", int'(err), 0);
    tick();

    run(15, 0, 1'b0);
    check_seq("t15", 4, 8, 12, 14, 15);
    check("t15_result", int'(result), 15);
    check("t15_steps", int'(steps), 4);
    tick();

    run(5, 2, 1'b0);
    check_seq("t5f", 2, 8, 4, 0, 0);
    check("t5f_err", int'(err), 1);
    check("t5f_result", int'(result), 0);
    check("t5f_steps", int'(steps), 2);
    tick();
    run(5, 0, 1'b0);
    check("t5_err", int'(err), 0);
    check("t5_result", int'(result), 5);
    check("t5_steps", int'(steps), 4);
    tick();

    // Reset during the third comparison aborts without a done pulse.
    tgt_q.push_back(13);
    fault_q.push_back(0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("abort_was_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_idle_done", int'(done), 0);
    run(6, 0, 1'b0);
    check("t6_result", int'(result), 6);
    check("t6_steps", int'(steps), 3);
    check("t6_err", int'(err), 0);
    tick();

    // start held high: back-to-back searches with period n+2.
    tgt_q.push_back(3);
    tgt_q.push_back(9);
    tgt_q.push_back(3);
    repeat (3) fault_q.push_back(0);
    start = 1'b1;
    cyc = 0;
    while (!(tgt_q.size() == 0 && done) && cyc < 60) begin
      tick();
      cyc++;
    end
    start = 1'b0;
    check("held_latency", cyc, 17);
    check("held_result", int'(result), 3);
    check("held_steps", int'(steps), 4);
    check("held_err", int'(err), 0);
    tick();
    tick();
    check("held_idle_busy", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cmp_search.md
CMP_SEARCH -- requirements
Module: cmp_search

Interface
REQ-001 Parameter W, default 4: width of the searched value and of guess/result; W >= 2 SHALL be supported.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new search; sampled only in IDLE.
REQ-005 guess  output  W  value driven to the external comparator "a" operand; the hidden target drives "b".
REQ-006 g  input  1  comparator response: guess > target.
REQ-007 e  input  1  comparator response: guess == target.
REQ-008 l  input  1  comparator response: guess < target.
REQ-009 busy  output  1  high while in SEARCH.
REQ-010 done  output  1  one-cycle pulse when result is valid.
REQ-011 result  output  W  recovered target value, held until the next start.
REQ-012 err  output  1  response-protocol violation flag, held until the next start.
REQ-013 steps  output  $clog2(W+1)  number of comparisons consumed by the last search.

Function
REQ-014 The block SHALL recover the hidden target by MSB-first successive approximation through the external combinational comparator, with at most W comparisons.
REQ-015 States SHALL be IDLE, SEARCH and DONE; IDLE -> SEARCH on start, SEARCH -> DONE on termination, and DONE -> IDLE unconditionally after one cycle.
REQ-016 On the IDLE edge with start=1, the block SHALL clear acc, err and steps, set bit index i=W-1 and enter SEARCH.
REQ-017 In SEARCH, guess SHALL equal acc | (1<<i); in IDLE and DONE, guess SHALL equal result.
REQ-018 g/e/l SHALL be sampled on each SEARCH edge, and steps SHALL increment by 1 per sample.
REQ-019 Response l (exactly one-hot) SHALL set acc bit i.
REQ-020 Response g (exactly one-hot) SHALL leave acc bit i clear.
REQ-021 Response e (exactly one-hot) SHALL set acc to the current guess and terminate immediately (early exit).
REQ-022 If the sample was for i=0 and the response was not e, the search SHALL terminate with acc as the result; otherwise i SHALL decrement by 1.
REQ-023 A response that is not one-hot (none or multiple of g/e/l asserted) SHALL set err=1 and terminate, with result = acc at that point.
REQ-024 On termination, result SHALL be loaded from the final acc, and done SHALL be high for exactly the DONE cycle.
REQ-025 Latency: done SHALL assert n+1 cycles after the start edge, where n = steps (1..W).
REQ-026 start asserted while busy or done is high SHALL be ignored; it SHALL NOT queue or restart the search.
REQ-027 start held continuously SHALL begin a new search on each IDLE cycle, giving back-to-back searches with a period of n+2.
REQ-028 Target 0 SHALL terminate after W comparisons with result 0 and no e response; this is not an error.

Reset
REQ-029 While rst=1, the block SHALL be in IDLE with busy=0, done=0, err=0, result=0, steps=0, acc=0 and guess=0.
REQ-030 rst asserted mid-SEARCH SHALL abort the search with no done pulse; after deassertion the block SHALL await a fresh start.
REQ-031 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification (W=4, model comparator in the bench)
REQ-032 Target 11, start pulse -> guesses 8,12,10,11; responses l,g,l,e -> done after 4 comparisons, result=11, steps=4, err=0.
REQ-033 Target 8 -> single guess 8 with response e -> done on the 2nd cycle after start, result=8, steps=1.
REQ-034 Targets 0 and 15 -> 0: guesses 8,4,2,1 all g, result=0, steps=4; 15: guesses 8,12,14,15 ending in e, result=15, steps=4.
REQ-035 Force g=e=1 on the 2nd comparison (target 5) -> err=1, done pulses, steps=2, result=0; the next start clears err.
REQ-036 Assert rst during the 3rd comparison -> busy=0 and no done pulse; a new search for target 6 then completes with result=6.
REQ-037 Hold start high across 3 searches (targets 3, 9, 3) -> each completes correctly, and start during busy never perturbs guess.
